// File: rtl/riscv_rf_pkg.sv
// Shared types for the regfile write path: data/address widths and the
// write-request record carried through the writeback stage register.
package riscv_rf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   rf_addr_t;
  typedef logic [XLEN-1:0] rf_data_t;

  typedef struct packed {
    logic     vld;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;

  // One-hot decode of a register index into an NREG-wide mask.
  function automatic logic [NREG-1:0] onehot_dec(input rf_addr_t addr);
    logic [NREG-1:0] mask;
    mask = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      if (addr == rf_addr_t'(i)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; the pointer names
// the source favoured on the next contended cycle and moves to the loser
// after each contended grant.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr_r;
  logic [1:0] gnt_s;

  // Grant selection: a lone requester always wins, contention follows rr_ptr_r.
  always_comb begin
    gnt_s = 2'b00;
    if (!en) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = rr_ptr_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Pointer update: after a contended grant, favour the source that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= RR_INIT;
    end else if (en && (req == 2'b11)) begin
      rr_ptr_r <= gnt_s[0];
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Writeback arbiter in front of the regfile write port. Two sources compete
// for one write per cycle; the winner is staged for one cycle and written on
// the following edge, while the staged write is forwarded to both read ports.
module regfile_wr_arbiter
  import riscv_rf_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [XLEN-1:0] s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [XLEN-1:0] s1_data,
  output logic            rf_we3,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic            byp1_hit,
  output logic [XLEN-1:0] byp1_data,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp2_data,
  output logic [NREG-1:0] pend_mask
);

  logic [1:0]      gnt_s;
  rf_wr_t          wr_nxt_s;
  rf_wr_t          wr_r;
  logic            we_s;
  logic            hit1_s;
  logic            hit2_s;
  logic [NREG-1:0] pend_s;

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~freeze),
    .req   ({s1_valid, s0_valid}),
    .gnt   (gnt_s)
  );

  // Next stage contents: the granted request, or an empty slot.
  always_comb begin
    wr_nxt_s = '0;
    if (gnt_s[0]) begin
      wr_nxt_s.vld  = 1'b1;
      wr_nxt_s.addr = s0_addr;
      wr_nxt_s.data = s0_data;
    end else if (gnt_s[1]) begin
      wr_nxt_s.vld  = 1'b1;
      wr_nxt_s.addr = s1_addr;
      wr_nxt_s.data = s1_data;
    end else begin
      wr_nxt_s = '0;
    end
  end

  // Stage register: reloads every edge, reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r <= '0;
    end else begin
      wr_r <= wr_nxt_s;
    end
  end

  // x0 filter, bypass compare and pending-register decode off the staged write.
  always_comb begin
    we_s   = wr_r.vld && (wr_r.addr != {AW{1'b0}});
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    pend_s = {NREG{1'b0}};
    if (we_s) begin
      hit1_s = (ra1 == wr_r.addr);
      hit2_s = (ra2 == wr_r.addr);
      pend_s = onehot_dec(wr_r.addr);
    end else begin
      hit1_s = 1'b0;
      hit2_s = 1'b0;
      pend_s = {NREG{1'b0}};
    end
  end

  assign s0_ready  = gnt_s[0];
  assign s1_ready  = gnt_s[1];
  assign rf_we3    = we_s;
  assign rf_a3     = wr_r.addr;
  assign rf_wd3    = wr_r.data;
  assign byp1_hit  = hit1_s;
  assign byp1_data = hit1_s ? wr_r.data : {XLEN{1'b0}};
  assign byp2_hit  = hit2_s;
  assign byp2_data = hit2_s ? wr_r.data : {XLEN{1'b0}};
  assign pend_mask = pend_s;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small behavioural regfile
// hanging off the write port.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        s0_valid, s0_ready;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s1_valid, s1_ready;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  ra1, ra2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
  logic [31:0] pend_mask;

  logic [31:0] rf_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .ra1(ra1), .ra2(ra2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural regfile: x0 is never written by the arbiter's filtered we3.
  always @(posedge clk) begin
    if (rf_we3) rf_mem[rf_a3] <= rf_wd3;
  end

  task automatic test_reset;
    #1;
    n_checks++; if (rf_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3 got=%b exp=0", rf_we3); end
    n_checks++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL reset_pend got=%h exp=0", pend_mask); end
    n_checks++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'h0) begin n_fail++; $display("FAIL reset_stage a3=%0d wd3=%h exp=0/0", rf_a3, rf_wd3); end
    n_checks++; if (byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin n_fail++; $display("FAIL reset_byp h1=%b h2=%b exp=0/0", byp1_hit, byp2_hit); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'hABCD1234; ra1 = 5'd1; ra2 = 5'd0;
    #1;
    n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready r0=%b r1=%b exp=1/0", s0_ready, s1_ready); end
    @(posedge clk); #1; s0_valid = 1'b0;
    n_checks++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd1 || rf_wd3 !== 32'hABCD1234) begin n_fail++; $display("FAIL single_wr we=%b a3=%0d wd=%h exp=1/1/abcd1234", rf_we3, rf_a3, rf_wd3); end
    n_checks++; if (pend_mask !== 32'h0000_0002) begin n_fail++; $display("FAIL single_pend got=%h exp=00000002", pend_mask); end
    n_checks++; if (byp1_hit !== 1'b1 || byp1_data !== 32'hABCD1234) begin n_fail++; $display("FAIL single_byp1 hit=%b data=%h exp=1/abcd1234", byp1_hit, byp1_data); end
    @(posedge clk); #1;
    n_checks++; if (rf_mem[1] !== 32'hABCD1234) begin n_fail++; $display("FAIL single_rf got=%h exp=abcd1234", rf_mem[1]); end
    n_checks++; if (rf_we3 !== 1'b0) begin n_fail++; $display("FAIL single_idle we=%b exp=0", rf_we3); end
  endtask

  task automatic test_round_robin;
    logic exp0;
    s0_valid = 1'b1; s0_addr = 5'd2; s0_data = 32'h12345678;
    s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      exp0 = ((k % 2) == 0);
      #1;
      n_checks++; if (s0_ready !== exp0 || s1_ready !== !exp0) begin n_fail++; $display("FAIL rr_grant%0d r0=%b r1=%b exp=%b/%b", k, s0_ready, s1_ready, exp0, !exp0); end
      @(posedge clk); #1;
      n_checks++; if (rf_a3 !== (exp0 ? 5'd2 : 5'd3) || rf_wd3 !== (exp0 ? 32'h12345678 : 32'hDEADBEEF)) begin n_fail++; $display("FAIL rr_wr%0d a3=%0d wd=%h", k, rf_a3, rf_wd3); end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rf_mem[2] !== 32'h12345678 || rf_mem[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rr_rf x2=%h x3=%h exp=12345678/deadbeef", rf_mem[2], rf_mem[3]); end
  endtask

  task automatic test_x0_drop;
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    n_checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL x0_ready r0=%b r1=%b exp=0/1", s0_ready, s1_ready); end
    @(posedge clk); #1; s1_valid = 1'b0;
    n_checks++; if (rf_we3 !== 1'b0 || pend_mask !== 32'h0) begin n_fail++; $display("FAIL x0_we we=%b pend=%h exp=0/0", rf_we3, pend_mask); end
    n_checks++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL x0_mirror a3=%0d wd=%h exp=0/ffffffff", rf_a3, rf_wd3); end
    n_checks++; if (byp1_hit !== 1'b0 || byp1_data !== 32'h0) begin n_fail++; $display("FAIL x0_byp hit=%b data=%h exp=0/0", byp1_hit, byp1_data); end
    @(posedge clk); #1;
    n_checks++; if (rf_mem[0] !== 32'h0) begin n_fail++; $display("FAIL x0_rf got=%h exp=0", rf_mem[0]); end
  endtask

  task automatic test_bypass;
    s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd0;
    @(posedge clk); #1; s1_valid = 1'b0;
    n_checks++; if (byp1_hit !== 1'b1 || byp1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp1 hit=%b data=%h exp=1/deadbeef", byp1_hit, byp1_data); end
    n_checks++; if (byp2_hit !== 1'b0 || byp2_data !== 32'h0) begin n_fail++; $display("FAIL byp2 hit=%b data=%h exp=0/0", byp2_hit, byp2_data); end
    n_checks++; if (pend_mask !== 32'h0000_0008) begin n_fail++; $display("FAIL byp_pend got=%h exp=00000008", pend_mask); end
    @(posedge clk); #1;
  endtask

  task automatic test_freeze;
    s0_valid = 1'b1; s0_addr = 5'd2; s0_data = 32'h12345678;
    s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL frz_pre r0=%b exp=1", s0_ready); end
    @(posedge clk); #1; freeze = 1'b1;
    n_checks++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd2) begin n_fail++; $display("FAIL frz_inflight we=%b a3=%0d exp=1/2", rf_we3, rf_a3); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL frz_ready%0d r0=%b r1=%b exp=0/0", k, s0_ready, s1_ready); end
      @(posedge clk); #1;
      n_checks++; if (rf_we3 !== 1'b0) begin n_fail++; $display("FAIL frz_we%0d we=%b exp=0", k, rf_we3); end
    end
    freeze = 1'b0;
    #1;
    n_checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL frz_release r0=%b r1=%b exp=0/1", s0_ready, s1_ready); end
    @(posedge clk); #1; s0_valid = 1'b0; s1_valid = 1'b0;
    n_checks++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd3) begin n_fail++; $display("FAIL frz_post we=%b a3=%0d exp=1/3", rf_we3, rf_a3); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_dest;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h11111111;
    s1_valid = 1'b1; s1_addr = 5'd5; s1_data = 32'h22222222;
    #1;
    n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL same_first r0=%b r1=%b exp=1/0", s0_ready, s1_ready); end
    @(posedge clk); #1; s0_valid = 1'b0;
    n_checks++; if (rf_a3 !== 5'd5 || rf_wd3 !== 32'h11111111) begin n_fail++; $display("FAIL same_wr0 a3=%0d wd=%h exp=5/11111111", rf_a3, rf_wd3); end
    #1;
    n_checks++; if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL same_second r1=%b exp=1", s1_ready); end
    @(posedge clk); #1; s1_valid = 1'b0;
    n_checks++; if (rf_a3 !== 5'd5 || rf_wd3 !== 32'h22222222) begin n_fail++; $display("FAIL same_wr1 a3=%0d wd=%h exp=5/22222222", rf_a3, rf_wd3); end
    @(posedge clk); #1;
    n_checks++; if (rf_mem[5] !== 32'h22222222) begin n_fail++; $display("FAIL same_rf got=%h exp=22222222", rf_mem[5]); end
  endtask

  task automatic test_reset_mid;
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h77777777; ra1 = 5'd7;
    @(posedge clk); #1; s0_valid = 1'b0;
    n_checks++; if (rf_we3 !== 1'b1 || byp1_hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre we=%b hit=%b exp=1/1", rf_we3, byp1_hit); end
    #2; rst_n = 1'b0;
    #1;
    n_checks++; if (rf_we3 !== 1'b0 || pend_mask !== 32'h0 || byp1_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop we=%b pend=%h hit=%b exp=0/0/0", rf_we3, pend_mask, byp1_hit); end
    n_checks++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'h0) begin n_fail++; $display("FAIL rstmid_stage a3=%0d wd=%h exp=0/0", rf_a3, rf_wd3); end
    @(posedge clk); #1;
    n_checks++; if (rf_mem[7] !== 32'h0) begin n_fail++; $display("FAIL rstmid_rf got=%h exp=0", rf_mem[7]); end
    #2; rst_n = 1'b1;
    s0_valid = 1'b1; s0_addr = 5'd2; s0_data = 32'h12345678;
    s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ptr r0=%b r1=%b exp=1/0", s0_ready, s1_ready); end
    @(posedge clk); #1; s0_valid = 1'b0; s1_valid = 1'b0;
    n_checks++; if (rf_a3 !== 5'd2) begin n_fail++; $display("FAIL rstmid_post a3=%0d exp=2", rf_a3); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst_n = 1'b0; freeze = 1'b0;
    s0_valid = 1'b0; s0_addr = 5'd0; s0_data = 32'h0;
    s1_valid = 1'b0; s1_addr = 5'd0; s1_data = 32'h0;
    ra1 = 5'd0; ra2 = 5'd0;
    #12;
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0_drop();
    test_bypass();
    test_freeze();
    test_same_dest();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
